// File: rtl/mux_lut_pkg.sv
// rtl/mux_lut_pkg.sv - shared types and sizing helpers for the mux-tree LUT array
package mux_lut_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Per-LUT config word: truth table plus one reg_mode bit on top.
    function automatic int lut_w(input int k);
        return (1 << k) + 1;
    endfunction

    function automatic int cfg_w(input int k, input int n_lut);
        return n_lut * lut_w(k);
    endfunction

endpackage

// File: rtl/mux_lut_array_if.sv
// rtl/mux_lut_array_if.sv - serial configuration chain handshake bundle
// cfg_start/cfg_valid/cfg_din driven by the loader (master);
// cfg_ready/cfg_busy/cfg_done driven by the LUT array (slave).
interface mux_lut_array_if;

    logic cfg_start;
    logic cfg_valid;
    logic cfg_din;
    logic cfg_ready;
    logic cfg_busy;
    logic cfg_done;

    modport master (
        output cfg_start, cfg_valid, cfg_din,
        input  cfg_ready, cfg_busy, cfg_done
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_din,
        output cfg_ready, cfg_busy, cfg_done
    );

endinterface

// File: rtl/mux_lut.sv
// rtl/mux_lut.sv - one K-input LUT built as a binary tree of 2:1 muxes
// truth : 2**K-bit truth table, bit i is the result for sel == i
// sel   : K select inputs, level i of the tree is steered by sel[i]
// y     : selected truth table bit (purely combinational)
module mux_lut #(
    parameter int K = 2
) (
    input  logic [2**K-1:0] truth,
    input  logic [K-1:0]    sel,
    output logic            y
);

    localparam int TW = 2**K;

    // Level by level reduction: after level i only the low TW>>(i+1) slots
    // are meaningful. Node n reads slots 2n/2n+1, which are never below n,
    // so rewriting in place in ascending order is safe.
    always_comb begin
        logic [TW-1:0] v;
        v = truth;
        for (int i = 0; i < K; i++) begin
            for (int n = 0; n < TW / 2; n++) begin
                if (n < (TW >> (i + 1))) begin
                    v[n] = sel[i] ? v[2*n+1] : v[2*n];
                end
            end
        end
        y = v[0];
    end

endmodule

// File: rtl/mux_lut_array.sv
// rtl/mux_lut_array.sv - array of runtime-programmable K-input mux-tree LUTs
// clk, rst_n : clock (rising edge) and asynchronous active-low reset
// cfg        : serial config chain (slave side), double-buffered shadow -> active
// lut_in     : select inputs shared by every LUT
// ce         : enable for the per-LUT output registers
// lut_out    : bit j is LUT j, combinational or registered per its reg_mode bit
module mux_lut_array
    import mux_lut_pkg::*;
#(
    parameter int K     = 2,
    parameter int N_LUT = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_lut_array_if.slave   cfg,
    input  logic [K-1:0]     lut_in,
    input  logic             ce,
    output logic [N_LUT-1:0] lut_out
);

    localparam int TW    = 2**K;
    localparam int LW    = lut_w(K);
    localparam int CFG_W = cfg_w(K, N_LUT);
    localparam int CW    = $clog2(CFG_W + 1);

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic [CFG_W-1:0]   shadow;
    logic [CFG_W-1:0]   active;
    logic               done_q;
    logic [N_LUT-1:0]   out_q;
    logic [N_LUT-1:0]   lut_val;
    logic [N_LUT-1:0]   reg_mode;
    logic               last_bit;

    // A restart in the same cycle as a valid bit discards that bit.
    assign last_bit = (cnt == CW'(CFG_W - 1));

    always_comb begin
        state_nxt     = state;
        cfg.cfg_ready = 1'b0;
        cfg.cfg_busy  = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (cfg.cfg_start) state_nxt = LOAD;
            end
            LOAD: begin
                cfg.cfg_ready = 1'b1;
                if (!cfg.cfg_start && cfg.cfg_valid && last_bit) state_nxt = COMMIT;
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= '0;
            active <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg.cfg_start) cnt <= '0;
                end
                LOAD: begin
                    if (cfg.cfg_start) begin
                        cnt <= '0;
                    end else if (cfg.cfg_valid) begin
                        shadow <= {shadow[CFG_W-2:0], cfg.cfg_din};
                        cnt    <= last_bit ? '0 : cnt + CW'(1);
                    end
                end
                COMMIT: begin
                    active <= shadow;
                    done_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign cfg.cfg_done = done_q;

    for (genvar j = 0; j < N_LUT; j++) begin : g_lut
        assign reg_mode[j] = active[j*LW + TW];

        mux_lut #(.K(K)) u_lut (
            .truth (active[j*LW +: TW]),
            .sel   (lut_in),
            .y     (lut_val[j])
        );
    end

    // Registers track regardless of mode so switching to registered output
    // never exposes data older than one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else if (ce) begin
            out_q <= lut_val;
        end
    end

    assign lut_out = (reg_mode & out_q) | (~reg_mode & lut_val);

endmodule
